// File: rtl/maccum_transpose_pkg.sv
// Shared types and fixed-point width helpers for the transposed MAC array.
package maccum_transpose_pkg;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_t;

   // Accumulator holds the full-precision sum of SIZE_B signed products.
   function automatic int accWidth(input int width, input int sizeB);
      return 2 * width + $clog2(sizeB);
   endfunction

   function automatic int outWidth(input int width, input int sizeB);
      return $clog2(sizeB) + width;
   endfunction

endpackage

// File: rtl/maccum_transpose_lane.sv
// One accumulator lane: signed multiply, accumulate with clear/enable, fixed-point output slice.
module maccum_transpose_lane import maccum_transpose_pkg::*; #(
   parameter int WIDTH  = 4,
   parameter int SIZE_B = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clr,
   input  logic                                  en,
   input  logic [WIDTH-1:0]                      w,
   input  logic [WIDTH-1:0]                      e,
   output logic [outWidth(WIDTH, SIZE_B)-1:0]    sum
);

   localparam int ACC_W = accWidth(WIDTH, SIZE_B);
   localparam int OUT_W = outWidth(WIDTH, SIZE_B);

   logic signed [2*WIDTH-1:0] prod;
   logic [ACC_W-1:0]          accQ, accD;
   logic                      unusedAcc;

   assign prod = $signed({{WIDTH{w[WIDTH-1]}}, w}) * $signed({{WIDTH{e[WIDTH-1]}}, e});

   always_comb begin
      accD = accQ;
      if (clr) begin
         accD = '0;
      end else if (en) begin
         accD = accQ + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) accQ <= '0;
      else     accQ <= accD;
   end

   // Slice the next-state value so the final row's product is visible on its own cycle;
   // when the lane is idle this equals the held accumulator.
   assign sum       = accD[WIDTH-1 +: OUT_W];
   assign unusedAcc = ^{accD[ACC_W-1], accD[WIDTH-2:0]};

endmodule

// File: rtl/maccum_transpose.sv
// Transposed matrix-vector MAC: delta[a] = sum_b W[b][a]*E[b], one weight row per cycle.
// Define MACCUM_TRANSPOSE_OVERLAP_EN for a separate output register that overlaps runs.
module maccum_transpose import maccum_transpose_pkg::*; #(
   parameter int SIZE_A = 32,
   parameter int SIZE_B = 32,
   parameter int WIDTH  = 4
) (
   input  logic                                        iCLK,
   input  logic                                        iRST,
   input  logic                                        iValid_AM_W,
   output logic                                        oReady_AM_W,
   input  logic [SIZE_B*SIZE_A*WIDTH-1:0]              iData_AM_W,
   input  logic                                        iValid_BM_E,
   output logic                                        oReady_BM_E,
   input  logic [SIZE_B*WIDTH-1:0]                     iData_BM_E,
   output logic                                        oValid_AM_WE,
   input  logic                                        iReady_AM_WE,
   output logic [SIZE_A*outWidth(WIDTH, SIZE_B)-1:0]   oData_AM_WE
);

   localparam int OUT_W = outWidth(WIDTH, SIZE_B);
   localparam int CNT_W = $clog2(SIZE_B);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(SIZE_B - 1);

   state_t                         stateQ, stateD;
   logic [CNT_W-1:0]               cntQ, cntD;
   logic [SIZE_B*SIZE_A*WIDTH-1:0] wQ;
   logic [SIZE_B*WIDTH-1:0]        eQ;
   logic                           accept, clr, en;
   logic [WIDTH-1:0]               wArr [SIZE_B][SIZE_A];
   logic [WIDTH-1:0]               eArr [SIZE_B];
   logic [SIZE_A*OUT_W-1:0]        laneSum;

   assign oReady_AM_W = (stateQ == StIdle) & iValid_BM_E;
   assign oReady_BM_E = (stateQ == StIdle) & iValid_AM_W;
   assign accept      = (stateQ == StIdle) & iValid_AM_W & iValid_BM_E;

   for (genvar b = 0; b < SIZE_B; b++) begin : gRow
      assign eArr[b] = eQ[b*WIDTH +: WIDTH];
      for (genvar a = 0; a < SIZE_A; a++) begin : gCol
         assign wArr[b][a] = wQ[(b*SIZE_A+a)*WIDTH +: WIDTH];
      end
   end

   for (genvar a = 0; a < SIZE_A; a++) begin : gLane
      maccum_transpose_lane #(
         .WIDTH  (WIDTH),
         .SIZE_B (SIZE_B)
      ) uLane (
         .clk (iCLK),
         .rst (iRST),
         .clr (clr),
         .en  (en),
         .w   (wArr[cntQ][a]),
         .e   (eArr[cntQ]),
         .sum (laneSum[a*OUT_W +: OUT_W])
      );
   end

`ifdef MACCUM_TRANSPOSE_OVERLAP_EN
   logic                    copyOut, outFree, outValidQ;
   logic [SIZE_A*OUT_W-1:0] outQ;

   assign outFree = ~outValidQ | iReady_AM_WE;
`endif

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      clr    = 1'b0;
      en     = 1'b0;
`ifdef MACCUM_TRANSPOSE_OVERLAP_EN
      copyOut = 1'b0;
`endif
      unique case (stateQ)
         StIdle: begin
            if (accept) begin
               stateD = StAccum;
               cntD   = '0;
               clr    = 1'b1;
            end
         end
         StAccum: begin
            en   = 1'b1;
            cntD = cntQ + 1'b1;
            if (cntQ == LAST_ROW) begin
               cntD = '0;
`ifdef MACCUM_TRANSPOSE_OVERLAP_EN
               if (outFree) begin
                  copyOut = 1'b1;
                  stateD  = StIdle;
               end else begin
                  stateD = StDone;
               end
`else
               stateD = StDone;
`endif
            end
         end
         StDone: begin
`ifdef MACCUM_TRANSPOSE_OVERLAP_EN
            // Accumulators hold until the previous result has left the output register.
            if (outFree) begin
               copyOut = 1'b1;
               stateD  = StIdle;
            end
`else
            if (iReady_AM_WE) stateD = StIdle;
`endif
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         stateQ <= StIdle;
         cntQ   <= '0;
         wQ     <= '0;
         eQ     <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (accept) begin
            wQ <= iData_AM_W;
            eQ <= iData_BM_E;
         end
      end
   end

`ifdef MACCUM_TRANSPOSE_OVERLAP_EN
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         outQ      <= '0;
         outValidQ <= 1'b0;
      end else if (copyOut) begin
         outQ      <= laneSum;
         outValidQ <= 1'b1;
      end else if (iReady_AM_WE) begin
         outValidQ <= 1'b0;
      end
   end

   assign oValid_AM_WE = outValidQ;
   assign oData_AM_WE  = outQ;
`else
   assign oValid_AM_WE = (stateQ == StDone);
   assign oData_AM_WE  = laneSum;
`endif

endmodule

// File: doc/maccum_transpose.md
Name: maccum_transpose

Overview:
- Backward-pass counterpart of the forward matrix-vector MAC array: computes delta_A[a] = sum over b of W[b][a]*E[b], i.e. transposed weight matrix times error vector.
- Time-multiplexed: one weight row per cycle into SIZE_A accumulator lanes.
- Uses the same valid/ready streaming protocol and the same fixed-point output slicing as the forward path.
- Sits between the error-propagation stage of layer N+1 and layer N's gradient logic.

Parameters:
- SIZE_A, 32, output vector length (forward-path input width); >=1.
- SIZE_B, 32, error vector length (forward-path output width); >=2.
- WIDTH, 4, element width, signed two's complement Q1.(WIDTH-1).

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset.
- iValid_AM_W  in  1  weight matrix valid.
- oReady_AM_W  out  1  weight matrix ready.
- iData_AM_W  in  SIZE_B*SIZE_A*WIDTH  weights; element W[b][a] at bit offset (b*SIZE_A+a)*WIDTH.
- iValid_BM_E  in  1  error vector valid.
- oReady_BM_E  out  1  error vector ready.
- iData_BM_E  in  SIZE_B*WIDTH  errors; E[b] at offset b*WIDTH.
- oValid_AM_WE  out  1  result valid.
- iReady_AM_WE  in  1  result ready.
- oData_AM_WE  out  SIZE_A*($clog2(SIZE_B)+WIDTH)  results; lane a at offset a*($clog2(SIZE_B)+WIDTH).

Behaviour:
- Clocking and reset: one clock, iCLK; reset iRST is asynchronous, active-high.
- Reset values: FSM=IDLE, row counter=0, accumulators=0, oValid_AM_WE=0, oData_AM_WE=0.
- FSM states: IDLE, ACCUM, DONE.
- Input join:
  - oReady_AM_W = (state==IDLE) & iValid_BM_E.
  - oReady_BM_E = (state==IDLE) & iValid_AM_W.
  - Both transfers therefore happen in the same cycle or not at all.
  - A lone valid is held without loss.
- IDLE -> ACCUM on accept: latch W and E into operand registers, clear accumulators, counter=0.
- ACCUM, each cycle:
  - acc[a] += sext(W[cnt][a]*E[cnt]) for all a in parallel.
  - Product width 2*WIDTH, signed; accumulator width 2*WIDTH+$clog2(SIZE_B).
  - cnt increments; when cnt==SIZE_B-1, go to DONE.
- DONE:
  - oValid_AM_WE=1.
  - oData lane a = acc[a][WIDTH-1 +: $clog2(SIZE_B)+WIDTH]: drop WIDTH-1 fraction LSBs; upper bits discarded, wrap, no saturation.
  - On oValid&iReady, return to IDLE and clear oValid_AM_WE.
- Latency: accept in cycle T; oValid_AM_WE high from T+SIZE_B+1. Throughput is one result per SIZE_B+2 cycles at best (non-overlap).
- Output stability: oData_AM_WE and oValid_AM_WE stay stable while oValid_AM_WE & ~iReady_AM_WE.
- iReady_AM_WE held high in DONE: hand-off completes in one cycle; no new input is accepted in that same cycle (non-overlap build).
- Input data changes while no transfer is occurring are ignored.
- Reset mid-ACCUM or mid-DONE: immediate return to reset values; the partial result is discarded and never presented.

Optional Feature:
- Macro: MACCUM_TRANSPOSE_OVERLAP_EN.
- Defined:
  - Separate output register.
  - On the ACCUM-complete cycle, results are copied into it and the FSM goes directly to IDLE, accepting new operands while the previous result is pending.
  - If the next ACCUM completes while the output register is still valid and not taken, the FSM stalls in DONE, accumulators hold, until the output transfers; then copy and go to IDLE.
  - Back-to-back throughput: one result per SIZE_B+1 cycles.
- Undefined: behaviour exactly as above; no extra register.

Decomposition:
- Shared package:
  - Fixed-point helpers: ACC_W(WIDTH,SIZE_B)=2*WIDTH+$clog2(SIZE_B); OUT_W=$clog2(SIZE_B)+WIDTH.
  - FSM state enum {IDLE, ACCUM, DONE}.
- One sub-module, maccum_transpose_lane:
  - Signed multiply plus accumulator with clear/enable and output slice.
  - Instantiated SIZE_A times; the top module holds the FSM, counter, operand registers and row mux.

Test Plan:
- SIZE_A=2, SIZE_B=2, WIDTH=4: W=[[4,4],[4,-4]], E=[4,4], both valid together, iReady=1 -> oData lanes {a0=4, a1=0}; oValid rises 3 cycles after accept.
- Same config: W all -8, E all -8 -> acc=128, slice wraps -> both lanes 5'b10000 (-16).
- iValid_AM_W high for 5 cycles before iValid_BM_E -> both readys low until E valid; single joint transfer; result correct.
- iReady_AM_WE low for 10 cycles in DONE -> oValid and oData held constant; both input readys stay 0; one transfer on release.
- Assert iRST during ACCUM cycle 1 with SIZE_B=4 -> oValid 0 immediately; next operand set yields a correct result with no residue from the aborted run.
- With MACCUM_TRANSPOSE_OVERLAP_EN, continuous valid inputs, iReady=1 -> results every SIZE_B+1 cycles; with iReady=0, second run stalls in DONE, first result unchanged.
